// File: rtl/screen_fader_pkg.sv
// screen_fader_pkg: register map, control bits and FSM states for the screen fader.
package screen_fader_pkg;
  localparam logic [2:0] FADER_CONTROL = 3'd0;
  localparam logic [2:0] FADER_TARGET = 3'd1;
  localparam logic [2:0] FADER_STEP = 3'd2;
  localparam logic [2:0] FADER_RATE = 3'd3;
  localparam logic [2:0] FADER_CURRENT = 3'd4;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fade_state_t;
endpackage

// File: rtl/screen_fader_if.sv
// screen_fader_if: memory-mapped bus hook shared by GPU blocks.
interface screen_fader_if;
  logic memenable;
  logic [2:0] memaddr;
  logic memwrite;
  logic [15:0] writedata;
  logic [15:0] memdata;
  modport master(output memenable, memaddr, memwrite, writedata, input memdata);
  modport slave(input memenable, memaddr, memwrite, writedata, output memdata);
endinterface

// File: rtl/screen_fader_fade_stepper.sv
// screen_fader_fade_stepper: one saturating brightness step toward target.
module screen_fader_fade_stepper (
  input  logic [7:0] current,
  input  logic [7:0] target,
  input  logic [7:0] step,
  output logic [7:0] next_value,
  output logic       at_target
);
  logic [8:0] eff, sum, diff;
  // 9-bit arithmetic: carry catches overshoot up, borrow catches underflow down
  always_comb begin
    eff = {1'b0, (step == 8'd0) ? 8'd1 : step};
    sum = {1'b0, current} + eff;
    diff = {1'b0, current} - eff;
    at_target = current == target;
    next_value = (current < target) ? ((sum > {1'b0, target}) ? target : sum[7:0]) :
                 (current > target) ? ((diff[8] || diff[7:0] < target) ? target : diff[7:0]) :
                 current;
  end
endmodule

// File: rtl/screen_fader.sv
// screen_fader: frame-synchronous brightness fader feeding the palette stage.
module screen_fader
  import screen_fader_pkg::*;
#(
  parameter logic [7:0] RESET_BRIGHTNESS = 8'd255,
  parameter int         RATE_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_tick,
  screen_fader_if.slave  bus,
  output logic [7:0]     brightness,
  output logic           busy,
  output logic           fade_done
);
  fade_state_t state, state_next;
  logic [7:0] target, step, stepped;
  logic [RATE_WIDTH-1:0] rate, count;
  logic [15:0] rd_value;
  logic wr, ctl_wr, start, abort, tick_due, step_now, at_target;
  logic unused_wd;

  assign unused_wd = ^bus.writedata[15:8];

  screen_fader_fade_stepper stepper (
    .current(brightness),
    .target(target),
    .step(step),
    .next_value(stepped),
    .at_target(at_target)
  );

  // a start or abort write in the same cycle swallows that frame tick
  always_comb begin
    wr = bus.memenable && bus.memwrite;
    ctl_wr = wr && bus.memaddr == FADER_CONTROL;
    abort = ctl_wr && bus.writedata[CTRL_ABORT];
    start = ctl_wr && bus.writedata[CTRL_START] && !abort;
    tick_due = state == RUN && frame_tick && !start && !abort;
    step_now = tick_due && count == rate;
    state_next = abort ? IDLE :
                 start ? (at_target ? DONE : RUN) :
                 step_now ? (stepped == target ? DONE : RUN) :
                 state == DONE ? IDLE : state;
    busy = state == RUN;
    fade_done = state == DONE;
    rd_value = bus.memaddr == FADER_CONTROL ? {15'd0, busy} :
               bus.memaddr == FADER_TARGET ? {8'd0, target} :
               bus.memaddr == FADER_STEP ? {8'd0, step} :
               bus.memaddr == FADER_RATE ? 16'(rate) :
               bus.memaddr == FADER_CURRENT ? {8'd0, brightness} : 16'd0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brightness <= RESET_BRIGHTNESS;
      target <= RESET_BRIGHTNESS;
      step <= 8'd1;
      rate <= '0;
      count <= '0;
      bus.memdata <= 16'd0;
    end else begin
      if (bus.memenable) bus.memdata <= rd_value;
      if (wr && bus.memaddr == FADER_TARGET) target <= bus.writedata[7:0];
      if (wr && bus.memaddr == FADER_STEP) step <= bus.writedata[7:0];
      if (wr && bus.memaddr == FADER_RATE) rate <= bus.writedata[RATE_WIDTH-1:0];
      if (wr && bus.memaddr == FADER_CURRENT && state == IDLE) brightness <= bus.writedata[7:0];
      else if (step_now) brightness <= stepped;
      count <= (start || step_now) ? '0 : tick_due ? count + 1'b1 : count;
    end
  end
endmodule
